alu_mc: RTL
===========

// Module: alu_mc
// PURPOSE
//  Parametrised multi-cycle ALU for the multi-cycle/pipelined datapath. Single-cycle
//  logic/arithmetic ops (same ctl codes as the existing gate-level ALU) return a
//  registered result after 1 cycle. Unsigned multiply, and optionally unsigned divide,
//  run iteratively over WIDTH cycles. Valid/ready handshake on both sides lets the
//  control FSM stall on a busy ALU.
// PARAMETERS
//  WIDTH   32   operand/result width in bits; must be >= 4.
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous, active-high reset
//  in_valid   in   1      operation request
//  in_ready   out  1      ALU can accept a request (state IDLE)
//  ctl        in   4      operation code, sampled on accept
//  a, b       in   WIDTH  operands, sampled on accept
//  out_valid  out  1      result valid; held until out_ready
//  out_ready  in   1      consumer takes result
//  out        out  WIDTH  result (MULTU: product low; DIVU: quotient)
//  out_hi     out  WIDTH  MULTU: product high; DIVU: remainder; else 0
//  z          out  1      result zero (MULTU: {out_hi,out}==0; else out==0)
//  ovf        out  1      signed overflow for ADD/SUB; else 0
// BEHAVIOUR
//  - ctl codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, MULTU 1000,
//    DIVU 1011, NOR 1100, XOR 1101. Any other code -> out=0, out_hi=0, ovf=0, z=1,
//    latency 1.
//  - Reset (async, any state, mid-operation included): state=IDLE, in_ready=1,
//    out_valid=0, out=0, out_hi=0, z=0, ovf=0, iteration counter=0. No partial result
//    survives reset.
//  - FSM states: IDLE, BUSY, DONE.
//    IDLE: accept when in_valid&&in_ready. MULTU/DIVU -> BUSY. Others -> DONE with the
//    result registered on the accept edge.
//    BUSY: one iteration per cycle, counter 0..WIDTH-1. After WIDTH iterations ->
//    DONE, result registered.
//    DONE: out_valid=1, out/out_hi/z/ovf stable. out_ready=1 -> IDLE next edge.
//  - in_ready=1 only in IDLE. No accept in BUSY or DONE. Simple-op throughput is 1 op
//    per 2 cycles when out_ready is held high.
//  - Latency from accept edge to out_valid: simple ops 1 cycle; MULTU/DIVU WIDTH+1
//    cycles.
//  - Arithmetic, all mod 2^WIDTH:
//    SUB = a + ~b + 1.
//    ovf(ADD) = (a[W-1]==b[W-1]) && (s[W-1]!=a[W-1]).
//    ovf(SUB) is the same test with ~b in place of b.
//    SLT is signed-correct: out = {W-1 zeros, diff[W-1]^ovf_sub}.
//  - MULTU: shift-add. {hi,lo} init {0,b}. Each iteration: if lo[0], hi += a with
//    carry. Then {carry,hi,lo} >>= 1. Full 2W-bit unsigned product.
//  - in_valid while not ready is ignored; the requester must hold it.
//  - out_ready while out_valid=0 is ignored.
// CONFIGURATION
//  ALU_DIV_EN defined: DIVU 1011 is a restoring unsigned divide, WIDTH iterations.
//    Result: out=a/b, out_hi=a%b.
//    b==0: out = all ones, out_hi = a, same latency.
//  ALU_DIV_EN undefined: 1011 is an unknown code (out=0, latency 1). No divider
//    logic is synthesised.
// STRUCTURE
//  - Shared include alu_defs.vh: localparams CTL_AND..CTL_DIVU, FSM state encodings
//    ST_IDLE/ST_BUSY/ST_DONE. The control unit includes the same file.
//  - One sub-module, alu_iter: iterative MULTU/DIVU datapath with start, done,
//    hi/lo registers and counter. alu_mc holds the FSM, single-cycle ops and output
//    registers.
// TESTING
//  1. ADD a=7FFFFFFF b=1, out_ready=1 -> out_valid 1 cycle after accept,
//     out=80000000, ovf=1, z=0. Then in_ready=1 the next cycle.
//  2. SLT a=80000000 b=7FFFFFFF -> out=1. SLT a=7FFFFFFF b=80000000 -> out=0.
//     SUB 5-5 -> out=0, z=1.
//  3. MULTU a=FFFFFFFF b=FFFFFFFF -> out_valid at cycle 33, out_hi=FFFFFFFE,
//     out=00000001. in_ready=0 during BUSY. in_valid pulses in BUSY are ignored.
//  4. Backpressure: NOR a=0 b=0 with out_ready=0 for 5 cycles -> out=FFFFFFFF held
//     stable, out_valid held. Drop to IDLE 1 cycle after out_ready=1.
//  5. reset asserted at MULTU iteration 10 -> out_valid=0, in_ready=1 immediately.
//     A following ADD 2+3 returns 5 correctly.
//  6. ALU_DIV_EN: DIVU 100/7 -> out=14, out_hi=2. DIVU 9/0 -> out=FFFFFFFF, out_hi=9.
//     Without the macro: DIVU -> out=0 after 1 cycle. Also run WIDTH=8.

Source files
------------

// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: shared ALU operation codes and FSM state encodings.
// Imported by alu_mc and by the control unit so both agree on ctl values.
// Macro ALU_DIV_EN: when defined, CTL_DIVU is an iterative (multi-cycle) op.
package alu_mc_pkg;

  localparam logic [3:0] CTL_AND   = 4'b0000;
  localparam logic [3:0] CTL_OR    = 4'b0001;
  localparam logic [3:0] CTL_ADD   = 4'b0010;
  localparam logic [3:0] CTL_SUB   = 4'b0110;
  localparam logic [3:0] CTL_SLT   = 4'b0111;
  localparam logic [3:0] CTL_MULTU = 4'b1000;
  localparam logic [3:0] CTL_DIVU  = 4'b1011;
  localparam logic [3:0] CTL_NOR   = 4'b1100;
  localparam logic [3:0] CTL_XOR   = 4'b1101;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // True for codes handled by the iterative datapath rather than in one cycle.
  function automatic logic is_iter_op(input logic [3:0] c);
`ifdef ALU_DIV_EN
    return (c == CTL_MULTU) || (c == CTL_DIVU);
`else
    return (c == CTL_MULTU);
`endif
  endfunction

endpackage

// File: rtl/alu_iter.sv
// alu_iter: iterative unsigned multiply (shift-add) and, with ALU_DIV_EN, restoring divide.
// Latency: load on start, then WIDTH iterations; 'last' is high during the final iteration cycle.
// Backpressure: none internally; hi/lo hold their value once idle until the next start.
// Ports: start loads operands; a,b operands; hi/lo result (product hi/lo, or remainder/quotient);
//        zero flags the result as zero; div (ALU_DIV_EN only) selects divide.
module alu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef ALU_DIV_EN
  input  logic             div,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH);

  logic             busy;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opnd;   // multiplicand, or divisor
  logic [WIDTH:0]   madd;   // hi plus conditional addend, with carry

  assign last = busy && (cnt == CW'(WIDTH - 1));
  assign madd = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);

`ifdef ALU_DIV_EN
  logic           div_r;
  logic [WIDTH:0] shifted;  // partial remainder shifted left, next dividend bit in
  logic [WIDTH:0] trial;    // borrow in trial[WIDTH] means "restore"

  assign shifted = {hi, lo[WIDTH-1]};
  assign trial   = shifted - {1'b0, opnd};
  assign zero    = div_r ? (lo == '0) : ({hi, lo} == '0);
`else
  assign zero    = ({hi, lo} == '0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy  <= 1'b0;
      cnt   <= '0;
      opnd  <= '0;
      hi    <= '0;
      lo    <= '0;
`ifdef ALU_DIV_EN
      div_r <= 1'b0;
`endif
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
      hi   <= '0;
`ifdef ALU_DIV_EN
      div_r <= div;
      opnd  <= div ? b : a;
      lo    <= div ? a : b;
`else
      opnd <= a;
      lo   <= b;
`endif
    end else if (busy) begin
      cnt <= last ? '0 : cnt + 1'b1;
      if (last) busy <= 1'b0;
`ifdef ALU_DIV_EN
      if (div_r) begin
        // Quotient bits shift into lo as dividend bits shift out of it.
        if (!trial[WIDTH]) begin
          hi <= trial[WIDTH-1:0];
          lo <= {lo[WIDTH-2:0], 1'b1};
        end else begin
          hi <= shifted[WIDTH-1:0];
          lo <= {lo[WIDTH-2:0], 1'b0};
        end
      end else begin
        hi <= madd[WIDTH:1];
        lo <= {madd[0], lo[WIDTH-1:1]};
      end
`else
      hi <= madd[WIDTH:1];
      lo <= {madd[0], lo[WIDTH-1:1]};
`endif
    end
  end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU; single-cycle logic/arith ops plus iterative MULTU (and DIVU with ALU_DIV_EN).
// Latency: simple ops 1 cycle from accept to out_valid; MULTU/DIVU WIDTH+1 cycles.
// Backpressure: in_ready only in IDLE; result and out_valid held in DONE until out_ready.
// Ports: clk/reset (async, active-high); in_valid/in_ready/ctl/a/b request side;
//        out_valid/out_ready/out/out_hi/z/ovf result side.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic             z,
  output logic             ovf
);

  logic [1:0]       state;
  logic             iter_sel;   // result comes from the iterative datapath registers
  logic [WIDTH-1:0] res_r;
  logic             z_r;
  logic             ovf_r;

  logic             accept;
  logic             it_start;
  logic             it_last;
  logic             it_zero;
  logic [WIDTH-1:0] it_hi;
  logic [WIDTH-1:0] it_lo;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             ovf_add;
  logic             ovf_sub;
  logic [WIDTH-1:0] res_c;
  logic             ovf_c;

  assign accept    = in_valid && in_ready;
  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign it_start  = accept && is_iter_op(ctl);

  assign sum     = a + b;
  assign diff    = a + ~b + 1'b1;
  assign ovf_add = (a[WIDTH-1] == b[WIDTH-1])  && (sum[WIDTH-1]  != a[WIDTH-1]);
  assign ovf_sub = (a[WIDTH-1] == ~b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    res_c = '0;
    ovf_c = 1'b0;
    case (ctl)
      CTL_AND: res_c = a & b;
      CTL_OR:  res_c = a | b;
      CTL_ADD: begin res_c = sum;  ovf_c = ovf_add; end
      CTL_SUB: begin res_c = diff; ovf_c = ovf_sub; end
      // Sign of the true difference, corrected for wrap-around.
      CTL_SLT: res_c = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ ovf_sub};
      CTL_NOR: res_c = ~(a | b);
      CTL_XOR: res_c = a ^ b;
      default: res_c = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      iter_sel <= 1'b0;
      res_r    <= '0;
      z_r      <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_iter_op(ctl)) begin
              state    <= ST_BUSY;
              iter_sel <= 1'b1;
            end else begin
              state    <= ST_DONE;
              iter_sel <= 1'b0;
              res_r    <= res_c;
              z_r      <= (res_c == '0);
              ovf_r    <= ovf_c;
            end
          end
        end
        ST_BUSY: if (it_last)   state <= ST_DONE;
        ST_DONE: if (out_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  alu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk   (clk),
    .reset (reset),
    .start (it_start),
`ifdef ALU_DIV_EN
    .div   (ctl == CTL_DIVU),
`endif
    .a     (a),
    .b     (b),
    .last  (it_last),
    .hi    (it_hi),
    .lo    (it_lo),
    .zero  (it_zero)
  );

  // Iterative results stay in the datapath's own registers; no second copy.
  assign out    = iter_sel ? it_lo   : res_r;
  assign out_hi = iter_sel ? it_hi   : '0;
  assign z      = iter_sel ? it_zero : z_r;
  assign ovf    = iter_sel ? 1'b0    : ovf_r;

endmodule
